instr_encoder: RTL
==================

// Module: instr_encoder
// PURPOSE
//  Inverse of the opcode decoder. Packs symbolic instruction requests (class, variant, operand) into
//  16-bit words {opcode[3:0], operand[11:0]} and streams them into instruction memory at sequential addresses.
//  Sits between the program-load/debug host port and the instruction RAM write port.
//  A 2-entry FIFO decouples host handshake from RAM backpressure.
// PARAMETERS
//  AW     8   instruction memory address width (words)
//  FDEPTH 2   output FIFO depth (fixed 2; other values unsupported)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   asynchronous, active-high reset
//  start        in   1   pulse: load base_addr, clear errors/count, IDLE->RUN
//  base_addr    in   AW  first write address, sampled on start
//  in_valid     in   1   request valid
//  in_ready     out  1   request accepted when in_valid & in_ready
//  in_class     in   3   0 IMM,1 BRANCH,2 MEM,3 STACK,4 SHIFT,5 ALU,6-7 illegal
//  in_sub       in   3   variant: bit0 for MEM/STACK/SHIFT, [2:0] for ALU, ignored otherwise
//  in_operand   in   12  operand field, passed through unchanged
//  in_last      in   1   marks final request of the program
//  mem_we       out  1   write strobe (valid on write port)
//  mem_addr     out  AW  write address
//  mem_wdata    out  16  encoded instruction word
//  mem_ready    in   1   RAM accepts write when mem_we & mem_ready
//  busy         out  1   state != IDLE
//  done         out  1   one-cycle pulse when program fully written
//  count        out  AW  words written since start
//  err_illegal  out  1   sticky: illegal class received
//  err_overflow out  1   sticky: write attempted past address 2**AW-1
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, mem_addr=0, count=0; all outputs 0.
//  Opcode map: IMM 0000; BRANCH 0001; MEM 001s; STACK 010s; SHIFT 011s (s=in_sub[0]); ALU 1,in_sub[2:0].
//   Check: decoder of this word returns the requested class (ALUs=01 for 10xx, 11 for 11xx).
//  States: IDLE --start--> RUN --in_last accepted--> DRAIN --FIFO empty--> IDLE (done=1 that cycle).
//  start ignored unless IDLE. start clears count, err_*, loads mem_addr=base_addr.
//  in_ready = (state==RUN) & FIFO not full; combinational from registered state only (no in_valid path).
//  Accepted legal beat enters FIFO; earliest mem_we for it is next cycle (latency 1, no bypass).
//  Illegal class: beat consumed (handshake completes), nothing enqueued, err_illegal set; in_last still ends RUN.
//  mem_we = FIFO not empty & !ovf_lock; mem_addr/mem_wdata stable while mem_we & !mem_ready.
//  On mem_we & mem_ready: pop, count+=1, mem_addr+=1; writing at 2**AW-1 sets ovf_lock (addr not wrapped).
//  ovf_lock: further FIFO entries popped silently (mem_we=0), err_overflow set; draining continues to IDLE.
//  Simultaneous push+pop on full FIFO: in_ready is 0 when full, so no push that cycle (no overrun possible).
//  Throughput: 1 word/cycle with mem_ready held high.
//  count saturates at 2**AW-1; errors cleared only by rst or start.
//  Reset mid-operation: FIFO flushed, in-flight words lost, mem_we drops immediately (async).
// TESTING
//  T1 base=0x10; ALU sub=3 op=0x0A5, last -> mem_we at addr 0x10, wdata 0xB0A5; done pulse; count=1.
//  T2 3 beats MEM s=1 op=0x012, STACK s=0 op=0x007, SHIFT s=1 op=0xFFF, mem_ready=1 -> 0x3012@b,0x4007@b+1,0x7FFF@b+2.
//  T3 mem_ready=0 for 5 cycles during 4-beat burst -> in_ready low after 2 accepts, wdata/addr stable, no loss.
//  T4 class=6 mid-stream -> err_illegal=1, neighbours written to consecutive addresses, count excludes it.
//  T5 base=0xFE (AW=8), 3 beats -> writes at 0xFE,0xFF only, err_overflow=1, done still pulses, busy clears.
//  T6 assert rst in DRAIN with 2 words queued -> mem_we=0 at once, busy=0, count=0; start afterwards works normally.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic instruction requests into 16-bit words
// {opcode[3:0], operand[11:0]} and streams them into instruction RAM at
// sequential addresses, through a 2-entry FIFO that absorbs RAM backpressure.
module instr_encoder #(
  parameter int AW     = 8,
  parameter int FDEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_class,
  input  logic [2:0]    in_sub,
  input  logic [11:0]   in_operand,
  input  logic          in_last,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] count,
  output logic          err_illegal,
  output logic          err_overflow
);

  localparam logic [AW-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  // FIFO storage: two slots, 1-bit pointers, occupancy counter 0..2
  logic [1:0][15:0] fifo_q, fifo_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       fcnt_q, fcnt_d;

  logic [AW-1:0]    addr_q, addr_d;
  logic [AW-1:0]    count_q, count_d;
  logic             err_ill_q, err_ill_d;
  logic             err_ovf_q, err_ovf_d;
  logic             ovf_lock_q, ovf_lock_d;

  logic fifo_empty, fifo_full;
  logic start_ok, accept, legal, push, pop, wr_fire;
  logic [15:0] enc_word;

  // Opcode map; the class field stays recoverable by the matching decoder
  function automatic logic [3:0] encode_op(input logic [2:0] cls,
                                           input logic [2:0] sub);
    logic [3:0] op;
    case (cls)
      3'd0:    op = 4'b0000;
      3'd1:    op = 4'b0001;
      3'd2:    op = {3'b001, sub[0]};
      3'd3:    op = {3'b010, sub[0]};
      3'd4:    op = {3'b011, sub[0]};
      3'd5:    op = {1'b1, sub};
      default: op = 4'b0000;
    endcase
    return op;
  endfunction

  assign fifo_empty = (fcnt_q == 2'd0);
  assign fifo_full  = (fcnt_q == 2'(FDEPTH));
  assign start_ok   = start && (state_q == S_IDLE);
  assign accept     = in_valid && in_ready;
  assign legal      = (in_class <= 3'd5);
  assign push       = accept && legal;
  // Once locked past the top address, entries are discarded without a write
  assign pop        = !fifo_empty && (ovf_lock_q || mem_ready);
  assign wr_fire    = pop && !ovf_lock_q;
  assign enc_word   = {encode_op(in_class, in_sub), in_operand};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: RUN until the last beat is accepted, then drain the FIFO
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok)               state_d = S_RUN;
      S_RUN:   if (accept && in_last)      state_d = S_DRAIN;
      S_DRAIN: if (fifo_empty)             state_d = S_IDLE;
      default:                             state_d = S_IDLE;
    endcase
  end

  // FSM outputs; in_ready depends only on registered state, never on in_valid
  always_comb begin
    in_ready = (state_q == S_RUN) && !fifo_full;
    mem_we   = !fifo_empty && !ovf_lock_q;
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DRAIN) && fifo_empty;
  end

  // FIFO next state: push at write pointer, pop at read pointer
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      fifo_d[wr_ptr_q] = enc_word;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
  end

  // Address, count and sticky error tracking
  always_comb begin
    addr_d     = addr_q;
    count_d    = count_q;
    err_ill_d  = err_ill_q;
    err_ovf_d  = err_ovf_q;
    ovf_lock_d = ovf_lock_q;
    if (start_ok) begin
      addr_d     = base_addr;
      count_d    = '0;
      err_ill_d  = 1'b0;
      err_ovf_d  = 1'b0;
      ovf_lock_d = 1'b0;
    end else begin
      if (accept && !legal) err_ill_d = 1'b1;
      if (pop && ovf_lock_q) err_ovf_d = 1'b1;
      if (wr_fire) begin
        if (count_q != ADDR_MAX) count_d = count_q + 1'b1;
        // Address is held at the top rather than wrapping onto word 0
        if (addr_q == ADDR_MAX) ovf_lock_d = 1'b1;
        else                    addr_d     = addr_q + 1'b1;
      end
    end
  end

  // Datapath registers; reset flushes the FIFO and drops mem_we at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q     <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fcnt_q     <= 2'd0;
      addr_q     <= '0;
      count_q    <= '0;
      err_ill_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
      ovf_lock_q <= 1'b0;
    end else begin
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      err_ill_q  <= err_ill_d;
      err_ovf_q  <= err_ovf_d;
      ovf_lock_q <= ovf_lock_d;
    end
  end

  assign mem_addr     = addr_q;
  assign mem_wdata    = fifo_q[rd_ptr_q];
  assign count        = count_q;
  assign err_illegal  = err_ill_q;
  assign err_overflow = err_ovf_q;

endmodule
